// File: rtl/edib_pkg.sv
// Shared types for the EDIB receiver: one-hot frame states, frame type codes
// and the sync pattern generator.
package edib_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_HUNT = 4'b0010,
    ST_DATA = 4'b0100,
    ST_DONE = 4'b1000
  } state_t;

  localparam logic TYPE_CMD  = 1'b0;
  localparam logic TYPE_DATA = 1'b1;

  localparam int SYNC_MAX = 16;

  // First line bit lands in the MSB: command is 1..1 0..0, data is 0..0 1..1.
  function automatic logic [2*SYNC_MAX-1:0] sync_pattern(input int len, input logic typ);
    logic [2*SYNC_MAX-1:0] half;
    half = (32'(1) << len) - 32'(1);
    return (typ == TYPE_CMD) ? (half << len) : half;
  endfunction

endpackage

// File: rtl/edib_bit_sampler.sv
// Line synchroniser, edge-resynchronised bit timer and majority-vote sampler.
// bit_stb/bit_dat are combinational from the timer; no backpressure.
module edib_bit_sampler #(
  parameter int BIT_CLKS = 576,
  parameter int SAMPLE_N = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic bit_dat,
  output logic bit_stb
);

  localparam int TW = $clog2(BIT_CLKS);
  localparam int SW = $clog2(SAMPLE_N + 1);
  localparam int W0 = BIT_CLKS / 2 - SAMPLE_N / 2;
  localparam logic [TW-1:0] T_LAST   = TW'(BIT_CLKS - 1);
  localparam logic [TW-1:0] T_WIN_LO = TW'(W0);
  localparam logic [TW-1:0] T_WIN_HI = TW'(W0 + SAMPLE_N - 1);
  localparam logic [TW-1:0] T_DEC    = TW'(W0 + SAMPLE_N);

  logic          sync1, sync2, prev;
  logic [TW-1:0] timer;
  logic [SW-1:0] sum;
  logic          line_edge;

  assign line_edge = (sync2 != prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
      timer <= '0;
      sum   <= '0;
    end else begin
      sync1 <= line;
      sync2 <= sync1;
      prev  <= sync2;
      if (line_edge || timer == T_LAST) timer <= '0;
      else                              timer <= timer + 1'b1;
      if (timer == '0)                                   sum <= '0;
      else if (timer >= T_WIN_LO && timer <= T_WIN_HI)   sum <= sum + SW'(sync2);
    end
  end

  // Strict majority; a tie with even SAMPLE_N resolves to 0.
  assign bit_stb = (timer == T_DEC);
  assign bit_dat = ({sum, 1'b0} > (SW + 1)'(SAMPLE_N));

endmodule

// File: rtl/edib_rx_param.sv
// EDIB serial receiver: sync hunt, Manchester-pair payload + odd parity, held word.
// rx_valid rises 2 Clk after the final bit strobe; a frame arriving while a word is unacked is dropped (overrun).
module edib_rx_param
  import edib_pkg::*;
#(
  parameter int BIT_CLKS     = 576,
  parameter int SAMPLE_N     = 12,
  parameter int DATA_W       = 16,
  parameter int SYNC_LEN     = 3,
  parameter int TIMEOUT_BITS = 10200
) (
  input  logic              Clk,
  input  logic              Rstn,
  input  logic              CMDIn,
  input  logic              en,
  input  logic              rx_ack,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_type,
  output logic              par_err,
  output logic              man_err,
  output logic              overrun,
  output logic [15:0]       frame_cnt,
  output logic              timeout
);

  localparam int SL2   = 2 * SYNC_LEN;
  localparam int NBITS = 2 * (DATA_W + 1);
  localparam int IW    = $clog2(NBITS);
  localparam int CW    = $clog2(SL2 + 1);
  localparam int HW    = $clog2(TIMEOUT_BITS + 1);
  localparam logic [SL2-1:0] SYNC_CMD  = SL2'(sync_pattern(SYNC_LEN, TYPE_CMD));
  localparam logic [SL2-1:0] SYNC_DATA = SL2'(sync_pattern(SYNC_LEN, TYPE_DATA));

  logic              bit_dat, bit_stb;
  state_t            state, state_nxt;
  logic [SL2-1:0]    sync_sr, sync_next;
  logic [CW-1:0]     sync_cnt;
  logic [HW-1:0]     hunt_cnt;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] data_sr;
  logic              par_bit, first_bit, man_flag, type_lat;
  logic              sync_full, sync_hit, last_bit, done;

  edib_bit_sampler #(.BIT_CLKS(BIT_CLKS), .SAMPLE_N(SAMPLE_N)) u_sampler (
    .clk     (Clk),
    .rst_n   (Rstn),
    .line    (CMDIn),
    .bit_dat (bit_dat),
    .bit_stb (bit_stb)
  );

  assign sync_next = {sync_sr[SL2-2:0], bit_dat};
  assign sync_full = (sync_cnt >= CW'(SL2 - 1));
  assign sync_hit  = bit_stb && sync_full && (sync_next == SYNC_CMD || sync_next == SYNC_DATA);
  assign last_bit  = bit_stb && (idx == IW'(NBITS - 1));

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (en) state_nxt = ST_HUNT;
      ST_HUNT: if (sync_hit) state_nxt = ST_DATA;
      ST_DATA: if (last_bit) state_nxt = ST_DONE;
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_HUNT;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!en) state_nxt = ST_IDLE;
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      sync_sr   <= '0;
      sync_cnt  <= '0;
      hunt_cnt  <= '0;
      idx       <= '0;
      data_sr   <= '0;
      par_bit   <= 1'b0;
      first_bit <= 1'b0;
      man_flag  <= 1'b0;
      type_lat  <= TYPE_CMD;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: if (en) begin
          sync_sr  <= '0;
          sync_cnt <= '0;
          hunt_cnt <= '0;
        end
        ST_HUNT: if (bit_stb) begin
          sync_sr <= sync_next;
          if (!sync_full) sync_cnt <= sync_cnt + 1'b1;
          if (sync_hit) begin
            type_lat <= (sync_next == SYNC_DATA) ? TYPE_DATA : TYPE_CMD;
            hunt_cnt <= '0;
            idx      <= '0;
            man_flag <= 1'b0;
          end else if (hunt_cnt == HW'(TIMEOUT_BITS - 1)) begin
            hunt_cnt <= '0;
            timeout  <= 1'b1;
          end else begin
            hunt_cnt <= hunt_cnt + 1'b1;
          end
        end
        ST_DATA: if (bit_stb) begin
          idx <= idx + 1'b1;
          // Even index carries the value, odd index must be its complement.
          if (!idx[0]) begin
            first_bit <= bit_dat;
            if (idx == IW'(NBITS - 2)) par_bit <= bit_dat;
            else                       data_sr <= {data_sr[DATA_W-2:0], bit_dat};
          end else if (bit_dat == first_bit) begin
            man_flag <= 1'b1;
          end
        end
        ST_DONE: begin
          sync_sr  <= '0;
          sync_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      rx_type   <= 1'b0;
      par_err   <= 1'b0;
      man_err   <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (done && (!rx_valid || rx_ack)) begin
        rx_valid  <= 1'b1;
        rx_data   <= data_sr;
        rx_type   <= type_lat;
        par_err   <= ~(^data_sr ^ par_bit);
        man_err   <= man_flag;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (rx_ack) begin
        rx_valid  <= 1'b0;
      end
      if (done && rx_valid && !rx_ack) overrun <= 1'b1;
      else if (rx_ack)                 overrun <= 1'b0;
    end
  end

endmodule
